sopc_data_mem_ctrl: RTL and testbench
=====================================

Name: sopc_data_mem_ctrl

Overview:
- Parametrised, multi-cycle data-memory controller that replaces the combinational data memory in the SOPC.
- Sits between the CPU memory stage and an on-chip RAM array. Uses a valid/ready request and one-cycle response handshake, with configurable read latency.
- Stores are byte, half or word with per-lane enables. Loads of byte or half are sign- or zero-extended.
- Misaligned and out-of-range accesses are detected. `busy` provides a pipeline stall.

Parameters:
- DATA_W, 32, data width in bits; fixed at 32; other values are illegal.
- DEPTH, 128, number of 32-bit words; power of two, 2..65536.
- LATENCY, 1, cycles from request accept to `resp_valid`; legal range 1..8.
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window. Only used when DMEM_MMIO_EN is defined.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data; right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle pulse; response is complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies `resp_valid`; access was rejected.
- busy  out  1  `req_valid` is high and a response is not yet delivered; CPU stall.

Behaviour:
- Reset:
  - FSM goes to IDLE; latency counter = 0.
  - `req_ready` = 1; `resp_valid` = 0; `resp_rdata` = 0; `resp_err` = 0; `busy` = 0.
  - RAM contents are not cleared.
- Reset mid-operation: the transaction is aborted with no response. A store is never committed if reset is high on its commit edge.
- FSM states:
  - IDLE: accept on `req_valid & req_ready`. Latch we/addr/size/unsigned/wdata. Counter = LATENCY-1. Go to WAIT.
  - WAIT: if counter == 0, go to RESP; else decrement.
  - RESP: `resp_valid` = 1 for exactly this cycle, then return to IDLE.
- Timing:
  - Accept on edge 0 → `resp_valid` is high in cycle LATENCY+1.
  - Minimum request spacing is LATENCY+2 cycles.
  - Inputs are ignored outside IDLE.
- Commit point:
  - Store write and load sample both occur on the WAIT→RESP edge, from the latched request.
  - A load issued after a store to the same word returns the new data.
- Word index = addr[clog2(DEPTH)+1:2].
  - An address is in range iff addr[31:clog2(DEPTH)+2] == 0.
- Byte lanes:
  - Byte: lane = addr[1:0]; byte data replicated on all lanes, written lane only.
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Errors (`resp_err` = 1, no write, `resp_rdata` = 0):
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - out of range.
- Load extension: the selected byte or half is shifted to bit 0, then extended per `req_unsigned`. Word loads are returned unmodified.
- `resp_rdata` and `resp_err` hold their value after the RESP cycle until the next RESP.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined:
  - MMIO_BASE+0: read-only 32-bit free-running cycle counter. Cleared by reset, wraps at 2^32.
  - MMIO_BASE+4: read/write register driving an extra output port `gpio_out[31:0]` (reset 0).
  - MMIO accesses must be word size; otherwise `resp_err` = 1.
  - A store to MMIO_BASE+0 gives `resp_err` = 1.
- Not defined: the `gpio_out` port and counter do not exist. MMIO addresses are treated as out-of-range (error).

Test Plan:
- LATENCY=1; word store 0xDEADBEEF @0x10, then word load @0x10 → `resp_valid` 2 cycles after each accept; load returns 0xDEADBEEF, `resp_err` = 0.
- Byte store 0x80 @0x13, then loads @0x13: signed → 0xFFFFFF80; unsigned → 0x00000080; word load @0x10 → 0x80ADBEEF.
- Half load @0x11 → `resp_err` = 1, `resp_rdata` = 0. Word store @0x22 → error; a word load @0x20 afterwards is unchanged.
- DEPTH=128; load @0x200 → `resp_err` = 1. LATENCY=4 → `resp_valid` in cycle 5; `req_ready` low cycles 1–5; `busy` high while `req_valid` is held.
- Store accepted, `reset` asserted in WAIT → no `resp_valid`; a later load shows the old data.
- DMEM_MMIO_EN: word store 0x5A @MMIO_BASE+4 → `gpio_out` = 0x5A. Two reads of MMIO_BASE+0 spaced N cycles apart differ by N. Byte store to MMIO_BASE+4 → error.

Source files
------------

// File: rtl/sopc_data_mem_ctrl.sv
// sopc_data_mem_ctrl: multi-cycle data-memory controller (byte/half/word, sign/zero-extended loads, error detection).
// Defining DMEM_MMIO_EN adds an MMIO window at MMIO_BASE: free-running cycle counter (+0) and GPIO register (+4, gpio_out).
module sopc_data_mem_ctrl #(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 128,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0]       gpio_out
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        stateReg;
    logic [2:0]    cntReg;
    logic          weReg;
    logic          unsReg;
    logic [1:0]    sizeReg;
    logic [31:0]   addrReg;
    logic [31:0]   wdataReg;

    logic          respErrReg;
    logic          respLoadReg;
    logic          respUnsReg;
    logic [1:0]    respSizeReg;
    logic [1:0]    respOffReg;

    logic          ramHit;
    logic          accErr;
    logic          commit;
    logic          ramWrite;
    logic [3:0]    laneEn;
    logic [31:0]   wdataRep;
    logic [31:0]   rawWord;
    logic [31:0]   extData;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [AW-1:0] wordIdx;

    assign wordIdx = addrReg[AW+1:2];
    // Stores write and loads sample on the WAIT->RESP edge; reset on that edge suppresses both.
    assign commit  = (stateReg == WAIT) && (cntReg == 3'd0) && !reset;

    always_comb begin
        ramHit   = 1'b0;
        laneEn   = 4'b0000;
        wdataRep = wdataReg;
        case (sizeReg)
            2'b00: begin
                ramHit   = 1'b1;
                laneEn   = 4'b0001 << addrReg[1:0];
                wdataRep = {4{wdataReg[7:0]}};
            end
            2'b01: begin
                ramHit   = !addrReg[0];
                laneEn   = addrReg[1] ? 4'b1100 : 4'b0011;
                wdataRep = {2{wdataReg[15:0]}};
            end
            2'b10: begin
                ramHit   = (addrReg[1:0] == 2'b00);
                laneEn   = 4'b1111;
            end
            default: ramHit = 1'b0;
        endcase
        ramHit = ramHit && (addrReg[31:AW+2] == '0);
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] cycleReg;
    logic [31:0] gpioReg;
    logic [31:0] mmioDataReg;
    logic        respMmioReg;
    logic        mmioHit;
    logic        mmioErr;

    assign mmioHit  = (addrReg == MMIO_BASE) || (addrReg == MMIO_BASE + 32'd4);
    assign mmioErr  = (sizeReg != 2'b10) || (weReg && (addrReg == MMIO_BASE));
    assign accErr   = mmioHit ? mmioErr : !ramHit;
    assign ramWrite = weReg && ramHit && !mmioHit;
    assign gpio_out = gpioReg;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycleReg <= '0;
            gpioReg  <= '0;
        end else begin
            cycleReg <= cycleReg + 32'd1;
            if (commit && weReg && mmioHit && !mmioErr)
                gpioReg <= wdataReg;
        end
    end
`else
    // Without the MMIO window its addresses are rejected even if MMIO_BASE overlaps the RAM range.
    localparam logic [28:0] MMIO_WIN = MMIO_BASE[31:3];

    assign accErr   = !ramHit || (addrReg[31:3] == MMIO_WIN);
    assign ramWrite = weReg && !accErr;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            respErrReg  <= 1'b0;
            respLoadReg <= 1'b0;
`ifdef DMEM_MMIO_EN
            respMmioReg <= 1'b0;
`endif
        end else begin
            case (stateReg)
                IDLE: begin
                    if (req_valid) begin
                        weReg    <= req_we;
                        addrReg  <= req_addr;
                        sizeReg  <= req_size;
                        unsReg   <= req_unsigned;
                        wdataReg <= req_wdata;
                        cntReg   <= 3'(LATENCY - 1);
                        stateReg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cntReg == 3'd0) begin
                        stateReg    <= RESP;
                        respErrReg  <= accErr;
                        respLoadReg <= !weReg && !accErr;
                        respSizeReg <= sizeReg;
                        respOffReg  <= addrReg[1:0];
                        respUnsReg  <= unsReg;
`ifdef DMEM_MMIO_EN
                        respMmioReg <= mmioHit && !weReg && !accErr;
                        mmioDataReg <= addrReg[2] ? gpioReg : cycleReg;
`endif
                    end else begin
                        cntReg <= cntReg - 3'd1;
                    end
                end
                RESP:    stateReg <= IDLE;
                default: stateReg <= IDLE;
            endcase
        end
    end

    // One byte-wide RAM per lane so each lane has a single writer and a registered read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] memArr [DEPTH];
            logic [7:0] rdByteReg;

            always_ff @(posedge clock) begin
                if (commit) begin
                    if (ramWrite && laneEn[gi])
                        memArr[wordIdx] <= wdataRep[8*gi +: 8];
                    rdByteReg <= memArr[wordIdx];
                end
            end

            assign rawWord[8*gi +: 8] = rdByteReg;
        end
    endgenerate

    always_comb begin
        byteSel = rawWord[{respOffReg, 3'b000} +: 8];
        halfSel = respOffReg[1] ? rawWord[31:16] : rawWord[15:0];
        case (respSizeReg)
            2'b00:   extData = respUnsReg ? {24'h0, byteSel} : {{24{byteSel[7]}}, byteSel};
            2'b01:   extData = respUnsReg ? {16'h0, halfSel} : {{16{halfSel[15]}}, halfSel};
            default: extData = rawWord;
        endcase
        resp_rdata = respLoadReg ? extData : '0;
`ifdef DMEM_MMIO_EN
        if (respMmioReg)
            resp_rdata = mmioDataReg;
`endif
    end

    assign req_ready  = (stateReg == IDLE);
    assign resp_valid = (stateReg == RESP);
    assign resp_err   = respErrReg;
    assign busy       = req_valid && (stateReg != RESP);

endmodule

// File: tb/tb_sopc_data_mem_ctrl.sv
// Directed bench: two controllers (LATENCY=1 and LATENCY=4) share the request bus and are checked side by side.
module tb_sopc_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        ready1, ready4, rv1, rv4, err1, err4, busy1, busy4;
    logic [31:0] rd1, rd4;
`ifdef DMEM_MMIO_EN
    logic [31:0] gpio1, gpio4;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sopc_data_mem_ctrl #(.DATA_W(32), .DEPTH(128), .LATENCY(1), .MMIO_BASE(32'hFFFF_0000)) dut1 (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
`ifdef DMEM_MMIO_EN
        , .gpio_out(gpio1)
`endif
    );

    sopc_data_mem_ctrl #(.DATA_W(32), .DEPTH(128), .LATENCY(4), .MMIO_BASE(32'hFFFF_0000)) dut4 (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready4), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv4), .resp_rdata(rd4), .resp_err(err4), .busy(busy4)
`ifdef DMEM_MMIO_EN
        , .gpio_out(gpio4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch both controllers for six cycles after the accept edge.
    task automatic doReq(input string tag, input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input logic expErr,
                         input logic chkData, input logic [31:0] expData,
                         output logic [31:0] got1, output logic [31:0] got4);
        int lat1 = 0, lat4 = 0, n1 = 0, n4 = 0, lo1 = 0, lo4 = 0;
        logic e1 = 1'bx, e4 = 1'bx;
        got1 = 'x;
        got4 = 'x;
        @(negedge clk);
        req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (rv1) begin n1++; if (lat1 == 0) lat1 = cyc; got1 = rd1; e1 = err1; end
            if (rv4) begin n4++; if (lat4 == 0) lat4 = cyc; got4 = rd4; e4 = err4; end
            if (!ready1) lo1++;
            if (!ready4) lo4++;
            if (cyc < 6) begin @(posedge clk); #1; end
        end
        check({tag, "/lat1"}, 32'(lat1), 32'd2);
        check({tag, "/lat4"}, 32'(lat4), 32'd5);
        check({tag, "/pulses1"}, 32'(n1), 32'd1);
        check({tag, "/pulses4"}, 32'(n4), 32'd1);
        check({tag, "/notready1"}, 32'(lo1), 32'd2);
        check({tag, "/notready4"}, 32'(lo4), 32'd5);
        check({tag, "/err1"}, {31'd0, e1}, {31'd0, expErr});
        check({tag, "/err4"}, {31'd0, e4}, {31'd0, expErr});
        if (chkData) begin
            check({tag, "/rdata1"}, got1, expData);
            check({tag, "/rdata4"}, got4, expData);
            check({tag, "/hold1"}, rd1, expData);
            check({tag, "/hold4"}, rd4, expData);
        end
        $display("txn %s we=%0d addr=%h size=%0d rdata1=%h rdata4=%h err=%0d/%0d",
                 tag, we, addr, size, got1, got4, e1, e4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g1, g4, c1, c4;
        int n1, n4;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/ready1", {31'd0, ready1}, 32'd1);
        check("rst/ready4", {31'd0, ready4}, 32'd1);
        check("rst/valid1", {31'd0, rv1}, 32'd0);
        check("rst/valid4", {31'd0, rv4}, 32'd0);
        check("rst/rdata1", rd1, 32'd0);
        check("rst/rdata4", rd4, 32'd0);
        check("rst/err1", {31'd0, err1}, 32'd0);
        check("rst/busy1", {31'd0, busy1}, 32'd0);
        reset = 1'b0;

        doReq("st_w10",   1, 32'h10,  2'b10, 0, 32'hDEADBEEF, 0, 1, 32'h0,        g1, g4);
        doReq("ld_w10",   0, 32'h10,  2'b10, 0, 32'h0,        0, 1, 32'hDEADBEEF, g1, g4);
        doReq("st_b13",   1, 32'h13,  2'b00, 0, 32'h00000080, 0, 1, 32'h0,        g1, g4);
        doReq("ld_bs13",  0, 32'h13,  2'b00, 0, 32'h0,        0, 1, 32'hFFFFFF80, g1, g4);
        doReq("ld_bu13",  0, 32'h13,  2'b00, 1, 32'h0,        0, 1, 32'h00000080, g1, g4);
        doReq("ld_w10b",  0, 32'h10,  2'b10, 0, 32'h0,        0, 1, 32'h80ADBEEF, g1, g4);
        doReq("ld_h11",   0, 32'h11,  2'b01, 0, 32'h0,        1, 1, 32'h0,        g1, g4);
        doReq("st_w20",   1, 32'h20,  2'b10, 0, 32'h12345678, 0, 1, 32'h0,        g1, g4);
        doReq("st_w22",   1, 32'h22,  2'b10, 0, 32'hAAAAAAAA, 1, 1, 32'h0,        g1, g4);
        doReq("ld_w20",   0, 32'h20,  2'b10, 0, 32'h0,        0, 1, 32'h12345678, g1, g4);
        doReq("ld_w200",  0, 32'h200, 2'b10, 0, 32'h0,        1, 1, 32'h0,        g1, g4);
        doReq("st_w14",   1, 32'h14,  2'b10, 0, 32'h11223344, 0, 1, 32'h0,        g1, g4);
        doReq("st_h16",   1, 32'h16,  2'b01, 0, 32'hFFFFBEEF, 0, 1, 32'h0,        g1, g4);
        doReq("ld_hs16",  0, 32'h16,  2'b01, 0, 32'h0,        0, 1, 32'hFFFFBEEF, g1, g4);
        doReq("ld_hu14",  0, 32'h14,  2'b01, 1, 32'h0,        0, 1, 32'h00003344, g1, g4);
        doReq("ld_bs15",  0, 32'h15,  2'b00, 0, 32'h0,        0, 1, 32'h00000033, g1, g4);
        doReq("ld_bs17",  0, 32'h17,  2'b00, 0, 32'h0,        0, 1, 32'hFFFFFFBE, g1, g4);
        doReq("ld_sz3",   0, 32'h14,  2'b11, 0, 32'h0,        1, 1, 32'h0,        g1, g4);
        doReq("st_w1fc",  1, 32'h1FC, 2'b10, 0, 32'h0BADCAFE, 0, 1, 32'h0,        g1, g4);
        doReq("ld_w1fc",  0, 32'h1FC, 2'b10, 0, 32'h0,        0, 1, 32'h0BADCAFE, g1, g4);
        doReq("st_w40",   1, 32'h40,  2'b10, 0, 32'hCAFEF00D, 0, 1, 32'h0,        g1, g4);

        // busy stays high while req_valid is held until the RESP cycle
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
        #1;
        check("busy/pre4", {31'd0, busy4}, 32'd1);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            check("busy/held4", {31'd0, busy4}, (cyc < 5) ? 32'd1 : 32'd0);
        end
        check("busy/valid4", {31'd0, rv4}, 32'd1);
        check("busy/rdata4", rd4, 32'h80ADBEEF);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("busy/ready4", {31'd0, ready4}, 32'd1);
        check("busy/ready1", {31'd0, ready1}, 32'd1);
        $display("txn busy_hold addr=00000010");

        // reset while the store is waiting to commit: no response, no write
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_size = 2'b10; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        n1 = 0;
        n4 = 0;
        for (int cyc = 2; cyc <= 7; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) reset = 1'b0;
            if (rv1) n1++;
            if (rv4) n4++;
        end
        check("rstmid/pulses1", 32'(n1), 32'd0);
        check("rstmid/pulses4", 32'(n4), 32'd0);
        check("rstmid/ready1", {31'd0, ready1}, 32'd1);
        check("rstmid/ready4", {31'd0, ready4}, 32'd1);
        check("rstmid/rdata1", rd1, 32'd0);
        $display("txn reset_mid_store addr=00000040");
        doReq("ld_w40",   0, 32'h40,  2'b10, 0, 32'h0,        0, 1, 32'hCAFEF00D, g1, g4);

`ifdef DMEM_MMIO_EN
        doReq("mm_gpio",  1, 32'hFFFF0004, 2'b10, 0, 32'h0000005A, 0, 1, 32'h0, g1, g4);
        check("mm/gpio1", gpio1, 32'h5A);
        check("mm/gpio4", gpio4, 32'h5A);
        doReq("mm_rdgp",  0, 32'hFFFF0004, 2'b10, 0, 32'h0, 0, 1, 32'h5A, g1, g4);
        doReq("mm_cnt_a", 0, 32'hFFFF0000, 2'b10, 0, 32'h0, 0, 0, 32'h0, c1, c4);
        doReq("mm_cnt_b", 0, 32'hFFFF0000, 2'b10, 0, 32'h0, 0, 0, 32'h0, g1, g4);
        check("mm/cntdiff1", g1 - c1, 32'd6);
        check("mm/cntdiff4", g4 - c4, 32'd6);
        doReq("mm_stb",   1, 32'hFFFF0004, 2'b00, 0, 32'h00000077, 1, 1, 32'h0, g1, g4);
        doReq("mm_stcnt", 1, 32'hFFFF0000, 2'b10, 0, 32'h00000001, 1, 1, 32'h0, g1, g4);
        check("mm/gpiokeep1", gpio1, 32'h5A);
`else
        doReq("mm_off_ld", 0, 32'hFFFF0000, 2'b10, 0, 32'h0,        1, 1, 32'h0, g1, g4);
        doReq("mm_off_st", 1, 32'hFFFF0004, 2'b10, 0, 32'h0000005A, 1, 1, 32'h0, g1, g4);
        c1 = 32'h0;
        c4 = 32'h0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
